// File: rtl/subroundconstant_pkg.sv
// Shared definitions for the Poseidon inverse add-round-constant stage.
// State encoding and default operand width.
package subroundconstant_pkg;

    localparam int DEFAULT_W = 256;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB1 = 2'd1,
        S_SUB2 = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/subroundconstant_arc_mod_sub.sv
// Combinational modular subtractor c = (a - b) mod p with a single +p correction.
// Exact for a, b < p; out-of-range operands get the same one-shot correction.
module arc_mod_sub #(
    parameter int WIDTH = subroundconstant_pkg::DEFAULT_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] c,
    output logic             borrow
);

    logic [WIDTH:0] diff;

    // One extra bit captures the borrow out of the raw subtraction.
    assign diff   = {1'b0, a} - {1'b0, b};
    assign borrow = diff[WIDTH];
    assign c      = borrow ? (diff[WIDTH-1:0] + p) : diff[WIDTH-1:0];

endmodule

// File: rtl/subroundconstant.sv
// Recovers x = (arc - pos_key - pre_key) mod p using one shared modular
// subtractor over two cycles, behind valid/ready handshakes on both sides.
module subroundconstant
    import subroundconstant_pkg::*;
#(
    parameter int IDW = DEFAULT_W,
    parameter int ODW = DEFAULT_W
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [IDW-1:0] i_arc,
    input  logic [IDW-1:0] i_pre_key,
    input  logic [IDW-1:0] i_pos_key,
    input  logic [IDW-1:0] i_p,
    output logic           o_valid,
    input  logic           i_rdy,
    output logic [ODW-1:0] o_x,
    output logic           o_flag
);

    state_t         state, state_nxt;
    logic [IDW-1:0] arc_r, pre_r, pos_r, p_r, t_r;
    logic           wrap_r;
    logic [IDW-1:0] sub_a, sub_b, sub_c;
    logic           sub_borrow;

    // Handshake outputs decode the state register only: no input-to-output path.
    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_nxt unassigned, which would otherwise infer a latch.
        state_nxt = state;
        unique case (state)
            S_IDLE: if (i_valid) state_nxt = S_SUB1;
            S_SUB1: state_nxt = S_SUB2;
            S_SUB2: state_nxt = S_DONE;
            S_DONE: if (i_rdy) state_nxt = S_IDLE;
        endcase
    end

    // SUB2 feeds the intermediate back through the same subtractor.
    assign sub_a = (state == S_SUB2) ? t_r   : arc_r;
    assign sub_b = (state == S_SUB2) ? pre_r : pos_r;

    arc_mod_sub #(.WIDTH(IDW)) u_sub (
        .a      (sub_a),
        .b      (sub_b),
        .p      (p_r),
        .c      (sub_c),
        .borrow (sub_borrow)
    );

    // NOTE: every register here uses non-blocking assignment so all updates
    // within one edge see the pre-edge values, matching real flip-flops.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= S_IDLE;
            arc_r  <= '0;
            pre_r  <= '0;
            pos_r  <= '0;
            p_r    <= '0;
            t_r    <= '0;
            wrap_r <= 1'b0;
            o_x    <= '0;
            o_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        arc_r  <= i_arc;
                        pre_r  <= i_pre_key;
                        pos_r  <= i_pos_key;
                        p_r    <= i_p;
                        wrap_r <= 1'b0;
                    end
                end
                S_SUB1: begin
                    t_r    <= sub_c;
                    wrap_r <= sub_borrow;
                end
                S_SUB2: begin
                    o_x    <= ODW'(sub_c);
                    o_flag <= wrap_r | sub_borrow;
                end
                S_DONE: ;
            endcase
        end
    end

endmodule
